// File: rtl/chip8_video_pkg.sv
// Shared constants and types for the chip8 video compositor.
package chip8_video_pkg;

  localparam int CHIP8_W       = 64;
  localparam int CHIP8_H       = 32;
  localparam int HDMI_H_ACTIVE = 1280;
  localparam int HDMI_V_ACTIVE = 720;

  typedef enum logic {
    GRID  = 1'b0,
    FOCUS = 1'b1
  } layout_mode_t;

  // Per-pixel attributes carried alongside the framebuffer read.
  typedef struct packed {
    logic [2:0] channel;
    logic       in_tile;
    logic       border;
  } pipe_t;

  // Out-of-range focus requests land on the last populated instance.
  function automatic logic [2:0] clamp_focus(input logic [2:0] focus, input int n_chip8);
    if (int'(focus) >= n_chip8) begin
      return 3'(n_chip8 - 1);
    end
    return focus;
  endfunction

endpackage

// File: rtl/chip8_video_compositor_if.sv
// Bus between the HDMI timing side, the chip8_video units and the compositor.
interface chip8_video_compositor_if #(
  parameter int N_CHIP8 = 4
);
  logic [10:0]        hcount_in;
  logic [9:0]         vcount_in;
  logic               active_in;
  logic               mode_in;
  logic [2:0]         focus_in;
  logic [N_CHIP8-1:0] chip8_pixel_in;
  logic [5:0]         chip8_x_out;
  logic [4:0]         chip8_y_out;
  logic               hdmi_pixel_out;
  logic               hdmi_tile_out;
  logic               hdmi_border_out;
  logic [2:0]         hdmi_channel_out;

  // Timing generator / framebuffer side.
  modport master (
    output hcount_in, vcount_in, active_in, mode_in, focus_in, chip8_pixel_in,
    input  chip8_x_out, chip8_y_out, hdmi_pixel_out, hdmi_tile_out,
    input  hdmi_border_out, hdmi_channel_out
  );

  // Compositor side.
  modport slave (
    input  hcount_in, vcount_in, active_in, mode_in, focus_in, chip8_pixel_in,
    output chip8_x_out, chip8_y_out, hdmi_pixel_out, hdmi_tile_out,
    output hdmi_border_out, hdmi_channel_out
  );
endinterface

// File: rtl/pixel_delay_line.sv
// Fixed-depth shift register used to align pixel attributes with the framebuffer read.
module pixel_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  // Shift one stage per clock; reset flushes every stage to zero.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/chip8_video_compositor.sv
// Maps HDMI pixel requests onto N_CHIP8 64x32 framebuffers in a grid or focus layout.
module chip8_video_compositor
  import chip8_video_pkg::*;
#(
  parameter int N_CHIP8          = 4,
  parameter int GRID_COLS        = 2,
  parameter int GRID_SCALE_LOG2  = 3,
  parameter int FOCUS_SCALE_LOG2 = 4,
  parameter int X0               = 128,
  parameter int Y0               = 104,
  parameter int BORDER           = 4,
  parameter int READ_LATENCY     = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  chip8_video_compositor_if.slave   bus
);

  typedef logic signed [11:0] coord_t;

  localparam int     GRID_ROWS = (N_CHIP8 + GRID_COLS - 1) / GRID_COLS;
  localparam coord_t GRID_W    = coord_t'((GRID_COLS * CHIP8_W) << GRID_SCALE_LOG2);
  localparam coord_t GRID_H    = coord_t'((GRID_ROWS * CHIP8_H) << GRID_SCALE_LOG2);
  localparam coord_t FOCUS_W   = coord_t'(CHIP8_W << FOCUS_SCALE_LOG2);
  localparam coord_t FOCUS_H   = coord_t'(CHIP8_H << FOCUS_SCALE_LOG2);
  localparam coord_t X0_C      = coord_t'(X0);
  localparam coord_t Y0_C      = coord_t'(Y0);
  localparam coord_t BORDER_C  = coord_t'(BORDER);

  layout_mode_t mode_reg;
  logic [2:0]   focus_reg;
  logic         frame_start;
  layout_mode_t mode_eff;
  logic [2:0]   focus_eff;

  coord_t       dx, dy, win_w, win_h;
  logic [11:0]  chan_wide;
  logic         inside_window, near_window;
  logic [5:0]   x_scaled, x_next, x_reg;
  logic [4:0]   y_scaled, y_next, y_reg;
  pipe_t        stage1_next, stage1_reg, delayed;
  logic [$bits(pipe_t)-1:0] delayed_bits;
  logic [7:0]   pix_ext;

  logic         pixel_reg, tile_reg, border_reg;
  logic [2:0]   channel_reg;

  // The frame-start pixel already uses the freshly captured layout.
  assign frame_start = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
  assign mode_eff    = frame_start ? layout_mode_t'(bus.mode_in) : mode_reg;
  assign focus_eff   = frame_start ? clamp_focus(bus.focus_in, N_CHIP8) : focus_reg;

  // Capture layout only at frame start so a frame never tears.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mode_reg  <= GRID;
      focus_reg <= 3'd0;
    end else if (frame_start) begin
      mode_reg  <= mode_eff;
      focus_reg <= focus_eff;
    end
  end

  // Window geometry, tile selection and framebuffer coordinates for this request.
  always_comb begin
    dx = coord_t'({1'b0, bus.hcount_in}) - X0_C;
    dy = coord_t'({2'b0, bus.vcount_in}) - Y0_C;
    if (mode_eff == FOCUS) begin
      win_w     = FOCUS_W;
      win_h     = FOCUS_H;
      chan_wide = {9'd0, focus_eff};
      x_scaled  = 6'(dx >>> FOCUS_SCALE_LOG2);
      y_scaled  = 5'(dy >>> FOCUS_SCALE_LOG2);
    end else begin
      win_w     = GRID_W;
      win_h     = GRID_H;
      chan_wide = 12'($unsigned(dy >>> (5 + GRID_SCALE_LOG2))) * 12'(GRID_COLS)
                + 12'($unsigned(dx >>> (6 + GRID_SCALE_LOG2)));
      x_scaled  = 6'(dx >>> GRID_SCALE_LOG2);
      y_scaled  = 5'(dy >>> GRID_SCALE_LOG2);
    end
    inside_window = (dx >= 12'sd0) && (dy >= 12'sd0) && (dx < win_w) && (dy < win_h);
    near_window   = (dx >= -BORDER_C) && (dy >= -BORDER_C) &&
                    (dx < win_w + BORDER_C) && (dy < win_h + BORDER_C);
    stage1_next.in_tile = bus.active_in && inside_window && (chan_wide < 12'(N_CHIP8));
    stage1_next.border  = bus.active_in && !inside_window && near_window;
    stage1_next.channel = stage1_next.in_tile ? 3'(chan_wide) : 3'd0;
    x_next              = stage1_next.in_tile ? x_scaled : 6'd0;
    y_next              = stage1_next.in_tile ? y_scaled : 5'd0;
  end

  // Stage 1: register the shared framebuffer request and pixel attributes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_reg      <= 6'd0;
      y_reg      <= 5'd0;
      stage1_reg <= '0;
    end else begin
      x_reg      <= x_next;
      y_reg      <= y_next;
      stage1_reg <= stage1_next;
    end
  end

  pixel_delay_line #(
    .WIDTH ($bits(pipe_t)),
    .DEPTH (READ_LATENCY)
  ) u_delay (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .din    (stage1_reg),
    .dout   (delayed_bits)
  );

  assign delayed = pipe_t'(delayed_bits);
  assign pix_ext = 8'(bus.chip8_pixel_in);

  // Output stage: pick the addressed instance's pixel once the read has returned.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_reg   <= 1'b0;
      tile_reg    <= 1'b0;
      border_reg  <= 1'b0;
      channel_reg <= 3'd0;
    end else begin
      pixel_reg   <= delayed.in_tile & pix_ext[delayed.channel];
      tile_reg    <= delayed.in_tile;
      border_reg  <= delayed.border;
      channel_reg <= delayed.channel;
    end
  end

  assign bus.chip8_x_out      = x_reg;
  assign bus.chip8_y_out      = y_reg;
  assign bus.hdmi_pixel_out   = pixel_reg;
  assign bus.hdmi_tile_out    = tile_reg;
  assign bus.hdmi_border_out  = border_reg;
  assign bus.hdmi_channel_out = channel_reg;

endmodule

// File: tb/tb_chip8_video_compositor.sv
// Directed bench for chip8_video_compositor: default 4-instance DUT plus a 3-instance DUT.
module tb_chip8_video_compositor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic b3_tile, b3_pix, b3_border;
  logic [2:0] b3_chan;

  chip8_video_compositor_if #(.N_CHIP8(4)) bus  ();
  chip8_video_compositor_if #(.N_CHIP8(3)) bus3 ();

  chip8_video_compositor #(.N_CHIP8(4)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  chip8_video_compositor #(.N_CHIP8(3)) dut3 (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0h", tag, got);
    end
  endtask

  task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic act);
    bus.hcount_in  = h;
    bus.vcount_in  = v;
    bus.active_in  = act;
    bus3.hcount_in = h;
    bus3.vcount_in = v;
    bus3.active_in = act;
  endtask

  task automatic set_layout(input logic mode, input logic [2:0] focus);
    bus.mode_in   = mode;
    bus.focus_in  = focus;
    bus3.mode_in  = mode;
    bus3.focus_in = focus;
  endtask

  task automatic set_pix(input logic [3:0] pix);
    bus.chip8_pixel_in  = pix;
    bus3.chip8_pixel_in = pix[2:0];
  endtask

  // One isolated pixel: request at t, x/y at t+1, framebuffer data at t+3, outputs at t+4.
  task automatic do_pixel(input string tag, input logic [10:0] h, input logic [9:0] v,
                          input logic act, input logic [3:0] pix,
                          input logic [5:0] ex, input logic [4:0] ey,
                          input logic et, input logic eb, input logic [2:0] ech,
                          input logic ep);
    drive(h, v, act);
    set_pix(~pix);
    @(posedge clk); #1;
    check({tag, ".x"}, 32'(bus.chip8_x_out), 32'(ex));
    check({tag, ".y"}, 32'(bus.chip8_y_out), 32'(ey));
    drive(11'd1500, 10'd700, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    check({tag, ".early"}, 32'(bus.hdmi_tile_out), 32'(0));
    set_pix(pix);
    @(posedge clk); #1;
    check({tag, ".pix"},    32'(bus.hdmi_pixel_out),   32'(ep));
    check({tag, ".tile"},   32'(bus.hdmi_tile_out),    32'(et));
    check({tag, ".border"}, 32'(bus.hdmi_border_out),  32'(eb));
    check({tag, ".chan"},   32'(bus.hdmi_channel_out), 32'(ech));
    b3_tile   = bus3.hdmi_tile_out;
    b3_pix    = bus3.hdmi_pixel_out;
    b3_border = bus3.hdmi_border_out;
    b3_chan   = bus3.hdmi_channel_out;
    set_pix(~pix);
  endtask

  initial begin
    drive(11'd1500, 10'd700, 1'b0);
    set_layout(1'b0, 3'd0);
    set_pix(4'b0000);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.x",      32'(bus.chip8_x_out),      32'(0));
    check("rst.y",      32'(bus.chip8_y_out),      32'(0));
    check("rst.pix",    32'(bus.hdmi_pixel_out),   32'(0));
    check("rst.tile",   32'(bus.hdmi_tile_out),    32'(0));
    check("rst.border", 32'(bus.hdmi_border_out),  32'(0));
    check("rst.chan",   32'(bus.hdmi_channel_out), 32'(0));

    // Grid layout (frame start latches grid)
    do_pixel("g_fs",     11'd0,    10'd0,   1'b1, 4'b1111, 6'd0,  5'd0,  1'b0, 1'b0, 3'd0, 1'b0);
    do_pixel("g_origin", 11'd128,  10'd104, 1'b1, 4'b0001, 6'd0,  5'd0,  1'b1, 1'b0, 3'd0, 1'b1);
    do_pixel("g_zero",   11'd128,  10'd104, 1'b1, 4'b1110, 6'd0,  5'd0,  1'b1, 1'b0, 3'd0, 1'b0);
    do_pixel("g_t0end",  11'd639,  10'd359, 1'b1, 4'b0001, 6'd63, 5'd31, 1'b1, 1'b0, 3'd0, 1'b1);
    do_pixel("g_t1",     11'd640,  10'd104, 1'b1, 4'b0010, 6'd0,  5'd0,  1'b1, 1'b0, 3'd1, 1'b1);
    do_pixel("g_t3",     11'd640,  10'd360, 1'b1, 4'b1111, 6'd0,  5'd0,  1'b1, 1'b0, 3'd3, 1'b1);
    check("n3_empty.tile",   32'(b3_tile),   32'(0));
    check("n3_empty.pix",    32'(b3_pix),    32'(0));
    check("n3_empty.border", 32'(b3_border), 32'(0));
    check("n3_empty.chan",   32'(b3_chan),   32'(0));
    do_pixel("g_bord",   11'd127,  10'd104, 1'b1, 4'b1111, 6'd0,  5'd0,  1'b0, 1'b1, 3'd0, 1'b0);
    do_pixel("g_nobord", 11'd120,  10'd104, 1'b1, 4'b1111, 6'd0,  5'd0,  1'b0, 1'b0, 3'd0, 1'b0);
    do_pixel("g_inact",  11'd300,  10'd200, 1'b0, 4'b1111, 6'd0,  5'd0,  1'b0, 1'b0, 3'd0, 1'b0);

    // Mid-frame layout change must be ignored until the next frame start
    set_layout(1'b1, 3'd2);
    do_pixel("mid_a",    11'd500,  10'd300, 1'b1, 4'b0001, 6'd46, 5'd24, 1'b1, 1'b0, 3'd0, 1'b1);
    do_pixel("mid_b",    11'd1151, 10'd615, 1'b1, 4'b1000, 6'd63, 5'd31, 1'b1, 1'b0, 3'd3, 1'b1);

    // Focus layout on instance 2
    do_pixel("f_fs",     11'd0,    10'd0,   1'b1, 4'b1111, 6'd0,  5'd0,  1'b0, 1'b0, 3'd0, 1'b0);
    do_pixel("f_end",    11'd1151, 10'd615, 1'b1, 4'b0100, 6'd63, 5'd31, 1'b1, 1'b0, 3'd2, 1'b1);
    do_pixel("f_origin", 11'd128,  10'd104, 1'b1, 4'b0100, 6'd0,  5'd0,  1'b1, 1'b0, 3'd2, 1'b1);
    do_pixel("f_mid",    11'd640,  10'd360, 1'b1, 4'b1011, 6'd32, 5'd16, 1'b1, 1'b0, 3'd2, 1'b0);
    do_pixel("f_bord",   11'd127,  10'd104, 1'b1, 4'b1111, 6'd0,  5'd0,  1'b0, 1'b1, 3'd0, 1'b0);
    do_pixel("f_nobord", 11'd120,  10'd104, 1'b1, 4'b1111, 6'd0,  5'd0,  1'b0, 1'b0, 3'd0, 1'b0);

    // Out-of-range focus clamps to the last instance
    set_layout(1'b1, 3'd7);
    do_pixel("clamp_fs", 11'd0,    10'd0,   1'b1, 4'b1111, 6'd0,  5'd0,  1'b0, 1'b0, 3'd0, 1'b0);
    do_pixel("clamp",    11'd200,  10'd200, 1'b1, 4'b1000, 6'd4,  5'd6,  1'b1, 1'b0, 3'd3, 1'b1);
    check("n3_clamp.chan", 32'(b3_chan), 32'(2));
    check("n3_clamp.tile", 32'(b3_tile), 32'(1));

    // Focus on instance 1, then a mid-line reset with a continuous pixel stream
    set_layout(1'b1, 3'd1);
    do_pixel("f1_fs",    11'd0,    10'd0,   1'b1, 4'b1111, 6'd0,  5'd0,  1'b0, 1'b0, 3'd0, 1'b0);
    do_pixel("f1",       11'd700,  10'd400, 1'b1, 4'b0010, 6'd35, 5'd18, 1'b1, 1'b0, 3'd1, 1'b1);

    drive(11'd700, 10'd400, 1'b1);
    set_pix(4'b1111);
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst.tile", 32'(bus.hdmi_tile_out),    32'(1));
    check("pre_rst.chan", 32'(bus.hdmi_channel_out), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst0.tile", 32'(bus.hdmi_tile_out),  32'(0));
    check("rst0.pix",  32'(bus.hdmi_pixel_out), 32'(0));
    check("rst0.x",    32'(bus.chip8_x_out),    32'(0));
    @(posedge clk); #1;
    check("rst1.x",    32'(bus.chip8_x_out),    32'(7));
    check("rst1.y",    32'(bus.chip8_y_out),    32'(5));
    check("rst1.tile", 32'(bus.hdmi_tile_out),  32'(0));
    for (int k = 2; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst%0d.tile", k), 32'(bus.hdmi_tile_out),  32'(0));
      check($sformatf("rst%0d.pix", k),  32'(bus.hdmi_pixel_out), 32'(0));
    end
    @(posedge clk); #1;
    check("rst4.tile", 32'(bus.hdmi_tile_out),    32'(1));
    check("rst4.pix",  32'(bus.hdmi_pixel_out),   32'(1));
    check("rst4.chan", 32'(bus.hdmi_channel_out), 32'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
